rv32m_muldiv_unit: RTL and testbench

//  Multi-cycle RV32M execute unit in the EX stage; computes MUL/MULH/MULHSU/MULHU and
//  DIV/DIVU/REM/REMU. Operands come from the EX operand muxes; the registered result goes to
//  the EX/MEM result mux. busy drives the hazard unit's pipeline stall.

---
 rtl/rv32m_muldiv_unit.sv | 158 +++++++++++++++
 tb/tb_rv32m_muldiv_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32m_muldiv_unit.sv
// RV32M execute unit: single-cycle registered multiply and a 32-step restoring divider.
// Results are registered in out and announced by a one-cycle done pulse.
module rv32m_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] out,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic        qneg_q, qneg_d, rneg_q, rneg_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] out_q, out_d;

  // Handshake: start is taken only when busy=0 (IDLE or DONE); done marks out valid for one cycle.
  logic        mul_a_sgn, mul_b_sgn;
  logic signed [63:0] mul_a, mul_b, prod;
  logic        div_sgn;
  logic        div_zero, div_ovf;
  logic [31:0] spec_res;
  logic [32:0] rem_sh;
  logic        ge;
  logic [31:0] sub;
  logic [31:0] q_fix, r_fix;

  assign mul_a_sgn = (op_q == 3'b001) || (op_q == 3'b010);
  assign mul_b_sgn = (op_q == 3'b001);
  assign mul_a     = {{32{mul_a_sgn & a_q[31]}}, a_q};
  assign mul_b     = {{32{mul_b_sgn & b_q[31]}}, b_q};
  assign prod      = mul_a * mul_b;

  assign div_sgn  = ~funct3[0];
  assign div_zero = (b_q == 32'd0);
  assign div_ovf  = ~op_q[0] && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
  assign spec_res = op_q[1] ? (div_zero ? a_q : 32'd0)
                            : (div_zero ? 32'hFFFF_FFFF : 32'h8000_0000);

  // The partial remainder stays below the divisor, so a 32-bit subtract suffices once ge holds.
  assign rem_sh = {rem_q, quo_q[31]};
  assign ge     = (rem_sh >= {1'b0, dvs_q});
  assign sub    = rem_sh[31:0] - dvs_q;
  assign q_fix  = qneg_q ? (32'd0 - quo_q) : quo_q;
  assign r_fix  = rneg_q ? (32'd0 - rem_q) : rem_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = 6'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          state_d = S_IDLE;
          if (start) begin
            op_d    = funct3;
            a_d     = in1;
            b_d     = in2;
            quo_d   = (div_sgn & in1[31]) ? (32'd0 - in1) : in1;
            dvs_d   = (div_sgn & in2[31]) ? (32'd0 - in2) : in2;
            rem_d   = 32'd0;
            qneg_d  = div_sgn & (in1[31] ^ in2[31]);
            rneg_d  = div_sgn & in1[31];
            cnt_d   = 6'd0;
            state_d = funct3[2] ? S_DIV : S_MUL;
          end
        end
        S_MUL: begin
          out_d   = (op_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
          state_d = S_DONE;
        end
        S_DIV: begin
          if ((cnt_q == 6'd0) && (div_zero || div_ovf)) begin
            out_d   = spec_res;
            state_d = S_DONE;
          end else begin
            quo_d = {quo_q[30:0], ge};
            rem_d = ge ? sub : rem_sh[31:0];
            if (cnt_q == 6'd31) begin
              cnt_d   = 6'd0;
              state_d = S_FIX;
            end else begin
              cnt_d = cnt_q + 6'd1;
            end
          end
        end
        S_FIX: begin
          out_d   = op_q[1] ? r_fix : q_fix;
          state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      quo_q   <= 32'd0;
      rem_q   <= 32'd0;
      dvs_q   <= 32'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= 6'd0;
      out_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign busy      = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
  assign done      = (state_q == S_DONE);
  assign out       = out_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Bench for rv32m_muldiv_unit: directed RV32M cases, flush/reset aborts, back-to-back
// issue and randomized ops compared against an arithmetic reference model.
module tb_rv32m_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic [2:0]  dbg_state;

  int tests;
  int errors;
  int cyc;
  logic [31:0] last_out;

  logic [31:0] exp_q[$];
  int          t_q[$];
  int          lat_q[$];

  rv32m_muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .flush     (flush),
    .funct3    (funct3),
    .in1       (in1),
    .in2       (in2),
    .busy      (busy),
    .done      (done),
    .out       (out),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  // reference model: plain 64-bit arithmetic on the RV32M definitions
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    longint      sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      3'b000, 3'b001, 3'b010, 3'b011: begin
        ea = (f == 3'b001 || f == 3'b010) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (f == 3'b001) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (f == 3'b000) ? p[31:0] : p[63:32];
      end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        r = sa / sb;
        return r[31:0];
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        r = sa % sb;
        return r[31:0];
      end
      3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 2;
    if (b == 0) return 2;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%h req=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // driver tasks: called at a negedge, return at the negedge of cycle t+1
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    funct3 = f;
    in1    = a;
    in2    = b;
    exp_q.push_back(model(f, a, b));
    t_q.push_back(cyc);
    lat_q.push_back(latency(f, a, b));
    @(negedge clk);
    start  = 1'b0;
    funct3 = 3'($urandom());
    in1    = $urandom();
    in2    = $urandom();
  endtask

  task automatic wait_done();
    for (int n = 0; n < 40; n++) begin
      if (done) return;
      check("busy_pending", 32'(busy), 32'd1);
      @(negedge clk);
    end
    tests++;
    errors++;
    $display("FAIL done_timeout act=no_done req=done_within_40 (cycle %0d)", cyc);
  endtask

  task automatic idle_check();
    @(negedge clk);
    check("done_pulse_len", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  task automatic directed(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lit);
    check("model_pin", model(f, a, b), lit);
    issue(f, a, b);
    wait_done();
    idle_check();
  endtask

  task automatic clear_expect();
    exp_q.delete();
    t_q.delete();
    lat_q.delete();
  endtask

  // scoreboard: every done pulse must match the oldest outstanding op in value and latency
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        tests++;
        errors++;
        $display("FAIL spurious_done act=done req=no_done out=%h (cycle %0d)", out, cyc);
      end else begin
        logic [31:0] e;
        int t, l;
        e = exp_q.pop_front();
        t = t_q.pop_front();
        l = lat_q.pop_front();
        check("result", out, e);
        check("latency", 32'(cyc - t), 32'(l));
        last_out = e;
      end
    end
  end

  initial begin
    tests    = 0;
    errors   = 0;
    last_out = 32'd0;
    rst_n    = 1'b0;
    start    = 1'b0;
    flush    = 1'b0;
    funct3   = 3'd0;
    in1      = 32'd0;
    in2      = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out", out, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    directed(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    directed(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    directed(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    directed(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    directed(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    directed(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    directed(3'b101, 32'd100,       32'd7,         32'd14);
    directed(3'b111, 32'd100,       32'd7,         32'd2);
    directed(3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF);
    directed(3'b110, 32'd5,         32'd0,         32'd5);
    directed(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    directed(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // flush at t+10 of a divide, with a competing start in the same cycle
    issue(3'b100, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    check("busy_before_flush", 32'(busy), 32'd1);
    flush  = 1'b1;
    start  = 1'b1;
    funct3 = 3'b000;
    in1    = 32'd3;
    in2    = 32'd5;
    clear_expect();
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_state", 32'(dbg_state), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    check("flush_out_held", out, last_out);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      check("flush_no_done", 32'(done), 32'd0);
    end

    // reset at t+5 of a divide
    issue(3'b100, 32'd77777, 32'd3);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_out", out, 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    clear_expect();
    last_out = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      check("midrst_no_done", 32'(done), 32'd0);
    end

    // back-to-back: the second op is issued in the DONE cycle of the first
    issue(3'b101, 32'd100, 32'd7);
    wait_done();
    issue(3'b000, 32'd6, 32'd7);
    wait_done();
    issue(3'b110, 32'hFFFF_FF00, 32'd9);
    wait_done();
    idle_check();

    // randomized ops, randomly back-to-back or with an idle cycle between
    for (int i = 0; i < 150; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom());
      a = pick();
      b = pick();
      issue(f, a, b);
      wait_done();
      if ($urandom_range(0, 1) == 1) idle_check();
    end
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
